// File: rtl/port_uart_tx.sv
// port_uart_tx: memory-mapped 8N1 UART transmitter with a one-entry holding
// register. It shares the CPU output bus with the output port bank and exposes
// {overrun, hold_full, busy} on port_status for the input-port read mux.
module port_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [7:0]  TX_ADDR      = 8'hF0,
    parameter logic [7:0]  CTRL_ADDR    = 8'hF1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] port_status
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       hold, hold_n;
    logic [2:0]       idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hold_full, hold_full_n;
    logic             overrun, overrun_n;
    logic             done_n, tx_n;
    logic             tx_wr, ctrl_clr, bit_end, stop_end, set_ovr;

    // State, counters, holding register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
            done      <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            overrun   <= overrun_n;
            done      <= done_n;
            tx        <= tx_n;
            busy      <= (state_n != IDLE);
        end
    end

    // Shifter contents are only observed in DATA, after a load, so no reset.
    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

    // Next-state, bus write handling and next output levels.
    always_comb begin
        state_n     = state;
        shift_n     = shift;
        hold_n      = hold;
        idx_n       = idx;
        hold_full_n = hold_full;
        done_n      = 1'b0;
        set_ovr     = 1'b0;

        tx_wr    = write && (address == TX_ADDR);
        ctrl_clr = write && (address == CTRL_ADDR) && data_in[0];
        bit_end  = (cnt == CNT_LAST);
        stop_end = (state == STOP) && bit_end;
        cnt_n    = bit_end ? '0 : cnt + 1'b1;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_wr && !hold_full) begin
                    shift_n = data_in;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_n = 1'b1;
                    if (hold_full) begin
                        // Held byte goes straight out; a simultaneous write refills hold.
                        shift_n = hold;
                        state_n = START;
                        if (tx_wr) begin
                            hold_n = data_in;
                        end else begin
                            hold_full_n = 1'b0;
                        end
                    end else if (tx_wr) begin
                        shift_n = data_in;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Writes that neither start a frame nor coincide with a stop completion.
        if (tx_wr && !stop_end && !((state == IDLE) && !hold_full)) begin
            if (!hold_full) begin
                hold_n      = data_in;
                hold_full_n = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end

        // Sticky overrun: a set in the same cycle beats a clear.
        if (set_ovr) begin
            overrun_n = 1'b1;
        end else if (ctrl_clr) begin
            overrun_n = 1'b0;
        end else begin
            overrun_n = overrun;
        end

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign port_status = {5'b0, overrun, hold_full, busy};

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed and randomized checks of port_uart_tx against a
// frame-position model (elapsed cycles since start bit -> line level).
module tb_port_uart_tx;

    localparam int         C   = 4;
    localparam logic [7:0] TXA = 8'hF0;
    localparam logic [7:0] CTA = 8'hF1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       write;
    logic       tx, busy, done;
    logic [7:0] port_status;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: a frame is "cur" started m_e cycles ago.
    logic       m_active = 1'b0;
    logic [7:0] m_cur    = '0;
    int         m_e      = 0;
    logic       m_hv     = 1'b0;
    logic [7:0] m_hb     = '0;
    logic       m_ovr    = 1'b0;
    logic       m_done   = 1'b0;
    logic       mdl_on   = 1'b0;

    logic lvl [0:9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    port_uart_tx #(.CLKS_PER_BIT(C), .TX_ADDR(TXA), .CTRL_ADDR(CTA)) dut (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write(write), .tx(tx), .busy(busy), .done(done), .port_status(port_status)
    );

    always #5 clk = ~clk;

    function automatic logic exp_tx();
        int p;
        if (!m_active) return 1'b1;
        p = m_e / C;
        if (p == 0) return 1'b0;
        if (p <= 8) return m_cur[p-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        logic tw, cw, se, so;
        if (reset) begin
            m_active = 0; m_e = 0; m_hv = 0; m_hb = '0; m_ovr = 0; m_done = 0;
            return;
        end
        tw = write && (address == TXA);
        cw = write && (address == CTA) && data_in[0];
        se = m_active && (m_e == 10*C - 1);
        so = 1'b0;
        m_done = se;
        if (se) begin
            if (m_hv) begin
                m_cur = m_hb; m_e = 0;
                if (tw) m_hb = data_in; else m_hv = 0;
            end else if (tw) begin
                m_cur = data_in; m_e = 0;
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            m_e++;
            if (tw) begin
                if (!m_hv) begin m_hb = data_in; m_hv = 1; end
                else so = 1'b1;
            end
        end else if (tw) begin
            m_active = 1; m_cur = data_in; m_e = 0;
        end
        if (so) m_ovr = 1;
        else if (cw) m_ovr = 0;
    endtask

    // Model advance on every edge, compare just after it.
    always @(posedge clk) begin
        logic       etx;
        logic [7:0] est;
        cyc++;
        model_step();
        if (reset) mdl_on = 1'b1;
        #1;
        if (mdl_on) begin
            etx = exp_tx();
            est = {5'b0, m_ovr, m_hv, m_active};
            checks++;
            if (tx !== etx || busy !== m_active || done !== m_done || port_status !== est) begin
                failures++;
                $display("FAIL model cyc=%0d tx=%b exp %b busy=%b exp %b done=%b exp %b status=%h exp %h",
                         cyc, tx, etx, busy, m_active, done, m_done, port_status, est);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one write at the next falling edge; the DUT samples it on the
    // following rising edge and the task returns at the falling edge after it.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    initial begin
        int dcount;
        int r;
        reset = 1'b1; write = 1'b0; address = '0; data_in = '0;
        wait_neg(2);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_status", port_status, 8'h00);
        reset = 1'b0;
        wait_neg(3);

        // Single frame 0xA5.
        do_write(TXA, 8'hA5);
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) wait_neg(1);
            chk("a5_tx", tx, (k < 40) ? lvl[k/C] : 1'b1);
            chk("a5_busy", busy, (k < 40) ? 1 : 0);
            chk("a5_done", done, (k == 40) ? 1 : 0);
        end
        wait_neg(3);

        // Back-to-back frames through the holding register.
        do_write(TXA, 8'h3C);
        wait_neg(3);
        do_write(TXA, 8'hC3);
        chk("b2b_status_held", port_status, 8'h03);
        wait_neg(35);
        chk("b2b_done1", done, 1);
        chk("b2b_tx_start2", tx, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_status_after", port_status, 8'h01);
        wait_neg(40);
        chk("b2b_done2", done, 1);
        chk("b2b_busy_end", busy, 0);
        chk("b2b_tx_end", tx, 1);
        wait_neg(3);

        // Overrun set, non-clearing control write, clearing control write.
        do_write(TXA, 8'h11);
        do_write(TXA, 8'h22);
        do_write(TXA, 8'hFF);
        chk("ovr_status", port_status, 8'h07);
        do_write(CTA, 8'h00);
        chk("ovr_keep", port_status, 8'h07);
        do_write(CTA, 8'h01);
        chk("ovr_clear", port_status, 8'h03);
        wait_neg(90);
        chk("ovr_idle", port_status, 8'h00);

        // Write landing on the exact stop-completion edge with hold empty.
        do_write(TXA, 8'h5A);
        wait_neg(38);
        do_write(TXA, 8'h55);
        chk("bnd_done", done, 1);
        chk("bnd_busy", busy, 1);
        chk("bnd_tx", tx, 0);
        chk("bnd_status", port_status, 8'h01);
        wait_neg(1);
        chk("bnd_done_once", done, 0);
        wait_neg(45);

        // Reset in the middle of a frame with a byte held.
        do_write(TXA, 8'h96);
        do_write(TXA, 8'h69);
        wait_neg(12);
        reset = 1'b1;
        wait_neg(1);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_status", port_status, 8'h00);
        reset = 1'b0;
        dcount = 0;
        repeat (50) begin
            wait_neg(1);
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        // Other addresses are ignored.
        do_write(8'hE0, 8'h00);
        chk("addr_e0_busy", busy, 0);
        do_write(8'hF2, 8'h55);
        chk("addr_f2_busy", busy, 0);
        wait_neg(5);
        chk("addr_tx", tx, 1);
        chk("addr_status", port_status, 8'h00);

        // Randomized traffic, checked every cycle by the model.
        repeat (4000) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            reset = (r == 99) && ($urandom_range(0, 3) == 0);
            write = 1'b0;
            data_in = 8'($urandom);
            if (r < 5) begin
                write = 1'b1; address = TXA;
            end else if (r < 8) begin
                write = 1'b1; address = CTA;
            end else if (r < 10) begin
                write = 1'b1; address = 8'($urandom);
            end
        end
        @(negedge clk);
        write = 1'b0; reset = 1'b0;
        wait_neg(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
# port_uart_tx

Memory-mapped 8N1 UART transmitter on the same CPU output bus (address, data_in, write) that drives the output port registers. A CPU write of a byte to the TX data address produces a serial frame on `tx`. It sits downstream of the CPU store path, in parallel with the output port bank. A one-entry holding register allows back-to-back frames with no idle gap. Status is exported as an 8-bit port for the input-port mux to read back.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥ 2.
- `TX_ADDR`, default 8'hF0: address of the TX data register.
- `CTRL_ADDR`, default 8'hF1: address of the control register. A write with data_in[0]=1 clears overrun.
- `clk` in, 1: single system clock, rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `address` in, 8: CPU bus address.
- `data_in` in, 8: CPU bus write data.
- `write` in, 1: write strobe, sampled on the rising edge of clk.
- `tx` out, 1: serial line, idles high.
- `busy` out, 1: high while a frame is being shifted.
- `done` out, 1: one-cycle pulse when a stop bit completes.
- `port_status` out, 8: {5'b0, overrun, hold_full, busy}.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Total length is 10*CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP. Registers:
  - shift register, 8 bits
  - bit index, 3 bits
  - baud counter, width $clog2(CLKS_PER_BIT)
  - hold register plus hold_full
  - overrun
- TX write means `write && address==TX_ADDR`. How it is handled depends on state:
  - IDLE with hold empty: byte loads into the shifter and the FSM goes to START.
  - Any other state with hold empty: byte loads into hold and hold_full is set.
  - hold_full=1 (and no stop completion this cycle): byte is dropped and overrun is set. Overrun is sticky.
- START, DATA and STOP each hold for CLKS_PER_BIT cycles, counted by the baud counter (0..CLKS_PER_BIT-1). The counter wraps to 0 at each bit boundary.
- DATA: tx = shift[0]. At each bit boundary the shifter shifts right and the bit index increments. After bit index 7 the FSM goes to STOP.
- End of STOP:
  - `done` pulses for one cycle.
  - If hold_full, hold moves into the shifter, hold_full clears, and the FSM goes directly to START, so there are 0 idle cycles between frames.
  - Otherwise the FSM goes to IDLE.
- TX write on the same cycle as the end of STOP:
  - hold_full=1: hold goes to the shifter and the new byte goes into hold. hold_full stays 1 and no overrun is raised.
  - hold_full=0: the new byte goes straight to the shifter, the FSM enters START, and hold stays empty.
- CTRL write with data_in[0]=1 clears overrun. If the same cycle also sets overrun, set wins. Writes to any other address are ignored.
- busy = (state != IDLE). tx = 1 in IDLE and STOP, 0 in START.

## Timing
- Reset values, one edge after reset is high: tx=1, busy=0, done=0, port_status=8'h00. The FSM is in IDLE and the counters, hold, hold_full and overrun are all 0.
- Reset mid-frame aborts the frame. tx returns high on the next edge and any held byte is discarded.
- Latency: a TX write sampled at edge N (FSM idle) gives tx=0 and busy=1 from edge N.
- Start bit falls at edge N. Data bit k occupies edges N+(k+1)*CLKS_PER_BIT through N+(k+2)*CLKS_PER_BIT-1.
- Stop bit begins at edge N+9*CLKS_PER_BIT.
- done is high for one cycle, from edge N+10*CLKS_PER_BIT. busy falls at the same edge unless a held byte is pending.
- All outputs are registered. There is no combinational path from the bus inputs to tx, busy, done or port_status.

## Test plan
- Reset checks: assert reset for 2 cycles, then check tx=1, busy=0, port_status=8'h00. Assert reset mid-frame at cycle 15 → tx=1 and busy=0 on the next edge, and no done pulse.
- Single frame, CLKS_PER_BIT=4: write 8'hA5 to F0 → tx reads 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. done pulses at cycle 40. busy is high on cycles 0–39.
- Back-to-back frames: write 8'h3C, then write 8'hC3 at cycle 5 → hold_full=1 (port_status=8'h03). The second start bit begins at cycle 40 with no idle gap, and done pulses at cycles 40 and 80.
- Overrun: with a frame active and hold full, write 8'hFF to F0 → byte dropped, port_status=8'h07. Then write 8'h01 to F1 → bit2 clears on the next edge.
- Boundary write: with hold empty, write 8'h55 on the exact cycle STOP ends → the new frame starts immediately, busy stays 1, done pulses once.
- Address filter: writes to E0 and F2 → tx stays high and busy stays 0.
